// File: rtl/pt2262_pkg.sv
// Shared types for the PT2262 frame encoder: symbol kinds, FSM states and
// the address-pair trit decode.
package pt2262_pkg;

  typedef enum logic [1:0] {
    SYM_0,
    SYM_1,
    SYM_F,
    SYM_SYNC
  } symbol_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FRAME_END
  } state_t;

  // 00 -> 0, 01 -> 1, 1x -> F (floating)
  function automatic symbol_t trit_decode(input logic [1:0] pair);
    if (pair[1]) begin
      return SYM_F;
    end
    if (pair[0]) begin
      return SYM_1;
    end
    return SYM_0;
  endfunction

endpackage

// File: rtl/pt2262_frame_encoder_if.sv
// Request/status bundle of the PT2262 frame encoder; the controller side
// uses master, the encoder uses slave.
interface pt2262_frame_encoder_if #(
  parameter int N_ADDR = 8,
  parameter int N_DATA = 4
);
  localparam int DW = (N_DATA > 0) ? N_DATA : 1;

  logic                  start;
  logic                  hold;
  logic [2*N_ADDR-1:0]   addr;
  logic [DW-1:0]         data;
  logic                  busy;
  logic                  cod_o;
  logic                  sync;
  logic                  frame_done;
  logic                  done;

  modport master (
    output start, hold, addr, data,
    input  busy, cod_o, sync, frame_done, done
  );

  modport slave (
    input  start, hold, addr, data,
    output busy, cod_o, sync, frame_done, done
  );

endinterface

// File: rtl/osc_tick_gen.sv
// Chip-rate oscillator modelled as a clock enable: one-cycle tick every
// CLK_DIV clk, counter held at zero while clr is high.
module osc_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(CLK_DIV - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = ~clr & (cnt_q == CNT_LAST);

endmodule

// File: rtl/pt2262_frame_encoder.sv
// PT2262-style tri-state encoder: serialises address trits, data bits and a
// sync symbol onto cod_o, repeating frames per start request or while hold.
//
// state        | meaning
// ST_IDLE      | waiting for start, cod_o low, tick counter held at 0
// ST_SEND      | stepping through chips of the current frame
// ST_FRAME_END | zero-cycle decision on the last tick: next frame or finish
module pt2262_frame_encoder #(
  parameter int N_ADDR    = 8,
  parameter int N_DATA    = 4,
  parameter int CLK_DIV   = 250,
  parameter int T_SHORT   = 4,
  parameter int T_LONG    = 12,
  parameter int T_SYNC_LO = 124,
  parameter int N_REPEAT  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  pt2262_frame_encoder_if.slave   bus
);
  import pt2262_pkg::*;

  localparam int DW       = (N_DATA > 0) ? N_DATA : 1;
  localparam int N_SYM    = N_ADDR + N_DATA;
  localparam int SW       = $clog2(N_SYM + 1);
  localparam int CHIP_MAX = (T_SYNC_LO > T_LONG) ? T_SYNC_LO : T_LONG;
  localparam int CW       = (CHIP_MAX > 1) ? $clog2(CHIP_MAX) : 1;
  localparam int RW       = $clog2(N_REPEAT + 1);

  localparam logic [SW-1:0] SYNC_IDX   = SW'(N_SYM);
  localparam logic [CW-1:0] SHORT_LAST = CW'(T_SHORT - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(T_LONG - 1);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(T_SYNC_LO - 1);
  localparam logic [RW-1:0] REP_MAX    = RW'(N_REPEAT);

  state_t              state_q, state_d, state_v;
  logic [2*N_ADDR-1:0] addr_q, addr_d;
  logic [DW-1:0]       data_q, data_d;
  logic [SW-1:0]       sym_q, sym_d;
  logic [1:0]          chip_q, chip_d;
  logic [CW-1:0]       chip_cnt_q, chip_cnt_d;
  logic [RW-1:0]       rep_q, rep_d;
  logic                cod_q, cod_d;
  logic                frame_done_q, frame_done_d;
  logic                done_q, done_d;

  logic                tick;
  logic                tick_clr;
  symbol_t             cur_sym;
  logic                is_long;
  logic [CW-1:0]       chip_last_cnt;
  logic                last_chip;
  logic                last_sym;
  logic [RW-1:0]       rep_next;
  logic                load_frame;

  assign tick_clr = (state_q == ST_IDLE);

  osc_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_osc (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

  always_comb begin
    cur_sym = SYM_SYNC;
    for (int i = 0; i < N_ADDR; i++) begin
      if (sym_q == SW'(i)) begin
        cur_sym = trit_decode(addr_q[2*i +: 2]);
      end
    end
    for (int j = 0; j < N_DATA; j++) begin
      if (sym_q == SW'(N_ADDR + j)) begin
        cur_sym = data_q[j] ? SYM_1 : SYM_0;
      end
    end
  end

  // Chip k of a symbol is high for even k; only the length varies.
  always_comb begin
    case (cur_sym)
      SYM_0:   is_long = chip_q[0];
      SYM_1:   is_long = ~chip_q[0];
      SYM_F:   is_long = chip_q[0] ^ chip_q[1];
      default: is_long = 1'b0;
    endcase
    chip_last_cnt = is_long ? LONG_LAST : SHORT_LAST;
    if ((cur_sym == SYM_SYNC) && chip_q[0]) begin
      chip_last_cnt = SYNC_LAST;
    end
    last_chip = (cur_sym == SYM_SYNC) ? (chip_q == 2'd1) : (chip_q == 2'd3);
    last_sym  = (sym_q == SYNC_IDX);
    rep_next  = (rep_q == REP_MAX) ? REP_MAX : rep_q + RW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      sym_q        <= '0;
      chip_q       <= '0;
      chip_cnt_q   <= '0;
      rep_q        <= '0;
      cod_q        <= 1'b0;
      frame_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      sym_q        <= sym_d;
      chip_q       <= chip_d;
      chip_cnt_q   <= chip_cnt_d;
      rep_q        <= rep_d;
      cod_q        <= cod_d;
      frame_done_q <= frame_done_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_v      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    sym_d        = sym_q;
    chip_d       = chip_q;
    chip_cnt_d   = chip_cnt_q;
    rep_d        = rep_q;
    cod_d        = cod_q;
    frame_done_d = 1'b0;
    done_d       = 1'b0;
    load_frame   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_v    = ST_SEND;
          rep_d      = '0;
          load_frame = 1'b1;
        end
      end
      ST_SEND: begin
        if (tick) begin
          if (chip_cnt_q != chip_last_cnt) begin
            chip_cnt_d = chip_cnt_q + CW'(1);
          end else begin
            chip_cnt_d = '0;
            if (!last_chip) begin
              chip_d = chip_q + 2'd1;
              cod_d  = ~cod_q;
            end else if (!last_sym) begin
              sym_d  = sym_q + SW'(1);
              chip_d = '0;
              cod_d  = 1'b1;
            end else begin
              state_v = ST_FRAME_END;
            end
          end
        end
      end
      default: state_v = ST_IDLE;
    endcase

    state_d = state_v;
    // Frame end resolves on the same edge so consecutive frames have no gap.
    if (state_v == ST_FRAME_END) begin
      frame_done_d = 1'b1;
      rep_d        = rep_next;
      if ((rep_next < REP_MAX) || bus.hold) begin
        state_d    = ST_SEND;
        load_frame = 1'b1;
      end else begin
        state_d = ST_IDLE;
        cod_d   = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (load_frame) begin
      addr_d     = bus.addr;
      data_d     = bus.data;
      sym_d      = '0;
      chip_d     = '0;
      chip_cnt_d = '0;
      cod_d      = 1'b1;
    end
  end

  always_comb begin
    bus.busy       = (state_q == ST_SEND);
    bus.cod_o      = cod_q;
    bus.sync       = cod_q & (sym_q == SYNC_IDX);
    bus.frame_done = frame_done_q;
    bus.done       = done_q;
  end

endmodule

// File: tb/tb_pt2262_frame_encoder.sv
// Randomised bench for pt2262_frame_encoder: per-clk waveform compared with
// a symbol-table reference model, covering repeat, hold, reset and restart.
module tb_pt2262_frame_encoder;

  localparam int CLK_DIV   = 4;
  localparam int TS        = 4;
  localparam int TL        = 12;
  localparam int TSY       = 124;
  localparam int FRAME_CLK = 2048;

  logic        clk;
  logic        reset_r;
  logic        start_r;
  logic        hold_r;
  logic [15:0] addr_r;
  logic [3:0]  data_r;
  logic        sel;

  int n_chk  = 0;
  int n_pass = 0;

  bit fr_cod[$];
  bit fr_sync[$];

  pt2262_frame_encoder_if #(.N_ADDR(8), .N_DATA(4)) if1 ();
  pt2262_frame_encoder_if #(.N_ADDR(8), .N_DATA(4)) if4 ();

  assign if1.start = start_r & ~sel;
  assign if1.hold  = hold_r;
  assign if1.addr  = addr_r;
  assign if1.data  = data_r;
  assign if4.start = start_r & sel;
  assign if4.hold  = hold_r;
  assign if4.addr  = addr_r;
  assign if4.data  = data_r;

  pt2262_frame_encoder #(.CLK_DIV(CLK_DIV), .N_REPEAT(1)) dut1 (
    .clk   (clk),
    .reset (reset_r),
    .bus   (if1.slave)
  );

  pt2262_frame_encoder #(.CLK_DIV(CLK_DIV), .N_REPEAT(4)) dut4 (
    .clk   (clk),
    .reset (reset_r),
    .bus   (if4.slave)
  );

  logic obs_busy, obs_cod, obs_sync, obs_fd, obs_done;
  assign obs_busy = sel ? if4.busy       : if1.busy;
  assign obs_cod  = sel ? if4.cod_o      : if1.cod_o;
  assign obs_sync = sel ? if4.sync       : if1.sync;
  assign obs_fd   = sel ? if4.frame_done : if1.frame_done;
  assign obs_done = sel ? if4.done       : if1.done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int want);
    n_chk++;
    if (obs == want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic add_chip(input int ticks, input bit level, input bit is_sync);
    for (int k = 0; k < ticks * CLK_DIV; k++) begin
      fr_cod.push_back(level);
      fr_sync.push_back(is_sync & level);
    end
  endtask

  task automatic add_sym(input int c0, input int c1, input int c2, input int c3);
    add_chip(c0, 1'b1, 1'b0);
    add_chip(c1, 1'b0, 1'b0);
    add_chip(c2, 1'b1, 1'b0);
    add_chip(c3, 1'b0, 1'b0);
  endtask

  // Expected cod_o / sync for one frame, one entry per clk
  task automatic build_frame(input logic [15:0] a, input logic [3:0] d);
    logic [1:0] trit;
    fr_cod.delete();
    fr_sync.delete();
    for (int i = 0; i < 8; i++) begin
      trit = a[2*i +: 2];
      if (trit[1])      add_sym(TS, TL, TL, TS);
      else if (trit[0]) add_sym(TL, TS, TL, TS);
      else              add_sym(TS, TL, TS, TL);
    end
    for (int j = 0; j < 4; j++) begin
      if (d[j]) add_sym(TL, TS, TL, TS);
      else      add_sym(TS, TL, TS, TL);
    end
    add_chip(TS, 1'b1, 1'b1);
    add_chip(TSY, 1'b0, 1'b1);
  endtask

  // Call at a negedge with start_r already driven. mode: 0 start released,
  // 1 random start pulses while busy, 2 start held high throughout.
  task automatic run_check(input int mode, input int hold_drop, input int chg_at,
                           input logic [15:0] a_new, input logic [3:0] d_new);
    int          nrep    = sel ? 4 : 1;
    int          n_end   = 0;
    bit          fin     = 1'b0;
    int          s       = 0;
    int          pos;
    int          e_cod = 0, e_sync = 0, e_busy = 0, e_fd = 0, e_done = 0;
    int          fd_cnt = 0, done_cnt = 0, done_at = -1;
    bit          x_cod, x_sync, x_busy, x_fd, x_done;
    bit          hold_prev = hold_r;
    logic [15:0] a_prev    = addr_r;
    logic [3:0]  d_prev    = data_r;
    build_frame(a_prev, d_prev);
    while (!fin && s < 20 * FRAME_CLK) begin
      @(negedge clk);
      pos    = s % FRAME_CLK;
      x_fd   = 1'b0;
      x_done = 1'b0;
      x_busy = 1'b1;
      if (s > 0 && pos == 0) begin
        n_end++;
        x_fd = 1'b1;
        if (n_end < nrep || hold_prev) begin
          build_frame(a_prev, d_prev);
        end else begin
          fin    = 1'b1;
          x_done = 1'b1;
          x_busy = 1'b0;
        end
      end
      x_cod  = fin ? 1'b0 : fr_cod[pos];
      x_sync = fin ? 1'b0 : fr_sync[pos];
      if (obs_cod  !== x_cod)  e_cod++;
      if (obs_sync !== x_sync) e_sync++;
      if (obs_busy !== x_busy) e_busy++;
      if (obs_fd   !== x_fd)   e_fd++;
      if (obs_done !== x_done) e_done++;
      if (obs_fd === 1'b1) fd_cnt++;
      if (obs_done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = s;
      end
      if (s == hold_drop) hold_r = 1'b0;
      if (s == chg_at) begin
        addr_r = a_new;
        data_r = d_new;
      end
      case (mode)
        0:       start_r = 1'b0;
        1:       start_r = fin ? 1'b0 : 1'($urandom_range(0, 1));
        default: start_r = 1'b1;
      endcase
      hold_prev = hold_r;
      a_prev    = addr_r;
      d_prev    = data_r;
      s++;
    end
    chk("run_end", int'(fin), 1);
    chk("cod_err", e_cod, 0);
    chk("sync_err", e_sync, 0);
    chk("busy_err", e_busy, 0);
    chk("frame_done_err", e_fd, 0);
    chk("done_err", e_done, 0);
    chk("frame_done_cnt", fd_cnt, n_end);
    chk("done_cnt", done_cnt, 1);
    chk("done_at", done_at, n_end * FRAME_CLK);
    @(negedge clk);
    chk("done_width", int'(obs_done), 0);
    chk("frame_done_width", int'(obs_fd), 0);
    chk("busy_after_done", int'(obs_busy), int'(mode == 2));
    chk("cod_after_done", int'(obs_cod), int'(mode == 2));
  endtask

  initial begin
    int post_cnt;
    reset_r = 1'b1;
    start_r = 1'b0;
    hold_r  = 1'b0;
    addr_r  = '0;
    data_r  = '0;
    sel     = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      chk("rst_busy", int'(obs_busy), 0);
      chk("rst_cod", int'(obs_cod), 0);
      chk("rst_sync", int'(obs_sync), 0);
      chk("rst_frame_done", int'(obs_fd), 0);
      chk("rst_done", int'(obs_done), 0);
    end
    @(negedge clk);
    reset_r = 1'b0;
    sel     = 1'b0;
    @(negedge clk);

    // all-zero frame, single repeat
    addr_r  = 16'h0000;
    data_r  = 4'b0000;
    start_r = 1'b1;
    run_check(0, -1, -1, 16'h0, 4'h0);

    // trits 1,1,1,1,F,F,F,F with data 1010
    addr_r  = 16'hAA55;
    data_r  = 4'b1010;
    start_r = 1'b1;
    run_check(0, -1, -1, 16'h0, 4'h0);

    for (int r = 0; r < 3; r++) begin
      addr_r  = 16'($urandom);
      data_r  = 4'($urandom_range(0, 15));
      start_r = 1'b1;
      run_check(0, -1, 700 + r * 300, 16'($urandom), 4'($urandom_range(0, 15)));
    end

    // four repeats with start noise and a mid-frame input change
    sel     = 1'b1;
    addr_r  = 16'($urandom);
    data_r  = 4'($urandom_range(0, 15));
    start_r = 1'b1;
    run_check(1, -1, FRAME_CLK + 777, 16'($urandom), 4'($urandom_range(0, 15)));

    // hold through six frames, drop in the seventh
    hold_r  = 1'b1;
    addr_r  = 16'($urandom);
    data_r  = 4'($urandom_range(0, 15));
    start_r = 1'b1;
    run_check(0, 6 * FRAME_CLK + 1000, 3 * FRAME_CLK - 700, addr_r, 4'($urandom_range(0, 15)));

    // start held high: restart one clk after done
    sel     = 1'b0;
    hold_r  = 1'b0;
    addr_r  = 16'($urandom);
    data_r  = 4'($urandom_range(0, 15));
    start_r = 1'b1;
    run_check(2, -1, -1, 16'h0, 4'h0);
    start_r = 1'b0;

    // asynchronous reset in the middle of the restarted frame
    @(posedge clk);
    #2;
    reset_r = 1'b1;
    #1;
    chk("mid_rst_busy", int'(obs_busy), 0);
    chk("mid_rst_cod", int'(obs_cod), 0);
    chk("mid_rst_sync", int'(obs_sync), 0);
    chk("mid_rst_frame_done", int'(obs_fd), 0);
    chk("mid_rst_done", int'(obs_done), 0);
    @(negedge clk);
    reset_r  = 1'b0;
    post_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (obs_busy === 1'b1 || obs_done === 1'b1 || obs_cod === 1'b1) post_cnt++;
    end
    chk("idle_after_rst", post_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
